src_mod_arbiter: RTL and testbench

SRC_MOD_ARBITER -- requirements
Module: src_mod_arbiter

---
 rtl/src_mod_arbiter.sv | 123 ++++++++++++
 tb/tb_src_mod_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/src_mod_arbiter.sv
// Two-requester arbiter with burst locking and a single output register stage.
// Each granted beat has its source modifier (neg/abs on lane sign bits) applied before it is registered.
module src_mod_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [127:0]     r0_data,
    input  logic             r0_neg,
    input  logic             r0_abs,
    input  logic             r0_last,
    input  logic [TAG_W-1:0] r0_tag,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [127:0]     r1_data,
    input  logic             r1_neg,
    input  logic             r1_abs,
    input  logic             r1_last,
    input  logic [TAG_W-1:0] r1_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_src
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    logic [1:0]       state;
    logic             rr_last;
    logic             vld_p0;
    logic [127:0]     data_p0;
    logic [TAG_W-1:0] tag_p0;
    logic             src_p0;

    logic             load_en;
    logic             gnt_vld;
    logic             gnt_sel;
    logic             accept;
    logic [127:0]     sel_data;
    logic             sel_neg;
    logic             sel_abs;
    logic             sel_last;
    logic [TAG_W-1:0] sel_tag;

    // abs clears the sign bit, neg flips it; both or neither leave the lane untouched
    function automatic logic [127:0] apply_mod(input logic [127:0] d, input logic neg, input logic abs);
        logic [127:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (abs && !neg)
                r[32*i+31] = 1'b0;
            else if (neg && !abs)
                r[32*i+31] = ~d[32*i+31];
        end
        return r;
    endfunction

    always_comb begin
        gnt_vld = 1'b0;
        gnt_sel = 1'b0;
        case (state)
            LOCK0: begin
                gnt_vld = r0_valid;
                gnt_sel = 1'b0;
            end
            LOCK1: begin
                gnt_vld = r1_valid;
                gnt_sel = 1'b1;
            end
            default: begin
                gnt_vld = r0_valid | r1_valid;
                gnt_sel = (r0_valid && r1_valid) ? ~rr_last : r1_valid;
            end
        endcase
    end

    assign load_en  = !vld_p0 || out_ready;
    assign accept   = gnt_vld && load_en && !flush && !rst;
    assign r0_ready = accept && !gnt_sel;
    assign r1_ready = accept && gnt_sel;

    assign sel_data = gnt_sel ? r1_data : r0_data;
    assign sel_neg  = gnt_sel ? r1_neg  : r0_neg;
    assign sel_abs  = gnt_sel ? r1_abs  : r0_abs;
    assign sel_last = gnt_sel ? r1_last : r0_last;
    assign sel_tag  = gnt_sel ? r1_tag  : r0_tag;

    // Stage p0: output register, loaded whenever the slot is empty or being drained
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            tag_p0  <= '0;
            src_p0  <= 1'b0;
            state   <= IDLE;
            rr_last <= 1'b1;
        end else if (flush) begin
            vld_p0 <= 1'b0;
            state  <= IDLE;
        end else if (load_en) begin
            vld_p0 <= accept;
            if (accept) begin
                data_p0 <= apply_mod(sel_data, sel_neg, sel_abs);
                tag_p0  <= sel_tag;
                src_p0  <= gnt_sel;
                rr_last <= gnt_sel;
                state   <= sel_last ? IDLE : (gnt_sel ? LOCK1 : LOCK0);
            end
        end
    end

    assign out_valid = vld_p0;
    assign out_data  = data_p0;
    assign out_tag   = tag_p0;
    assign out_src   = src_p0;

endmodule

// File: tb/tb_src_mod_arbiter.sv
// Randomized and directed bench for src_mod_arbiter, checked every cycle against a behavioural model.
module tb_src_mod_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         r0_valid, r1_valid, r0_ready, r1_ready;
    logic [127:0] r0_data, r1_data;
    logic         r0_neg, r0_abs, r0_last, r1_neg, r1_abs, r1_last;
    logic [3:0]   r0_tag, r1_tag;
    logic         flush, out_valid, out_ready, out_src;
    logic [127:0] out_data;
    logic [3:0]   out_tag;

    int n_cmp = 0;
    int n_bad = 0;

    src_mod_arbiter #(.TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_data(r0_data), .r0_neg(r0_neg),
        .r0_abs(r0_abs), .r0_last(r0_last), .r0_tag(r0_tag),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_data(r1_data), .r1_neg(r1_neg),
        .r1_abs(r1_abs), .r1_last(r1_last), .r1_tag(r1_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .out_src(out_src)
    );

    always #5 clk = ~clk;

    // Model state: lock owner (-1 = none), last winner, and the registered beat
    int           m_lock;
    logic         m_rr;
    logic         m_ov;
    logic [127:0] m_data;
    logic [3:0]   m_tag;
    logic         m_src;
    int           m_g;

    function automatic logic [127:0] model_mod(input logic [127:0] d, input logic n, input logic a);
        logic [127:0] r;
        logic [31:0]  l;
        r = d;
        for (int i = 0; i < 4; i++) begin
            l = d[32*i +: 32];
            if (a && !n) l = l & 32'h7FFF_FFFF;
            else if (n && !a) l = l ^ 32'h8000_0000;
            r[32*i +: 32] = l;
        end
        return r;
    endfunction

    function automatic int exp_gnt();
        if (rst || flush || (m_ov && !out_ready)) return -1;
        if (m_lock == 0) return r0_valid ? 0 : -1;
        if (m_lock == 1) return r1_valid ? 1 : -1;
        if (r0_valid && r1_valid) return m_rr ? 0 : 1;
        if (r0_valid) return 0;
        if (r1_valid) return 1;
        return -1;
    endfunction

    always_comb m_g = exp_gnt();

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ov <= 1'b0; m_data <= '0; m_tag <= '0; m_src <= 1'b0;
            m_lock <= -1; m_rr <= 1'b1;
        end else if (flush) begin
            m_ov <= 1'b0; m_lock <= -1;
        end else if (!m_ov || out_ready) begin
            m_ov <= (m_g >= 0);
            if (m_g == 0) begin
                m_data <= model_mod(r0_data, r0_neg, r0_abs);
                m_tag <= r0_tag; m_src <= 1'b0; m_rr <= 1'b0;
                m_lock <= r0_last ? -1 : 0;
            end else if (m_g == 1) begin
                m_data <= model_mod(r1_data, r1_neg, r1_abs);
                m_tag <= r1_tag; m_src <= 1'b1; m_rr <= 1'b1;
                m_lock <= r1_last ? -1 : 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("r0_ready", {127'd0, r0_ready}, {127'd0, m_g == 0});
            chk("r1_ready", {127'd0, r1_ready}, {127'd0, m_g == 1});
            chk("out_valid", {127'd0, out_valid}, {127'd0, m_ov});
            if (m_ov) begin
                chk("out_data", out_data, m_data);
                chk("out_tag", {124'd0, out_tag}, {124'd0, m_tag});
                chk("out_src", {127'd0, out_src}, {127'd0, m_src});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        r0_valid = 0; r1_valid = 0; r0_data = '0; r1_data = '0;
        r0_neg = 0; r0_abs = 0; r0_last = 1; r0_tag = '0;
        r1_neg = 0; r1_abs = 0; r1_last = 1; r1_tag = '0;
        flush = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        r0_valid = 1;
        out_ready = 0;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_tag", {124'd0, out_tag}, 128'd0);
        chk("rst_r0_ready", {127'd0, r0_ready}, 128'd0);
        rst = 1'b0;

        // neg on 1.0 gives -1.0 in every lane
        r0_valid = 1; r0_data = {4{32'h3F80_0000}}; r0_neg = 1; r0_abs = 0;
        r0_last = 1; r0_tag = 4'h5; out_ready = 1;
        @(negedge clk); #3;
        chk("neg_valid", {127'd0, out_valid}, 128'd1);
        chk("neg_data", out_data, {4{32'hBF80_0000}});
        chk("neg_src", {127'd0, out_src}, 128'd0);
        chk("neg_tag", {124'd0, out_tag}, 128'd5);
        r0_valid = 0; r1_valid = 1; r1_data = {4{32'hC000_0000}};
        r1_abs = 1; r1_neg = 0; r1_last = 1; r1_tag = 4'hA;
        @(negedge clk); #3;
        chk("abs_data", out_data, {4{32'h4000_0000}});
        chk("abs_src", {127'd0, out_src}, 128'd1);
        r1_neg = 1;
        @(negedge clk); #3;
        chk("absneg_data", out_data, {4{32'hC000_0000}});

        // alternating ties
        r0_valid = 1; r1_valid = 1; r0_neg = 0; r1_neg = 0; r1_abs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #3;
            chk("rr_src", {127'd0, out_src}, {127'd0, (i % 2) == 1});
            chk("rr_valid", {127'd0, out_valid}, 128'd1);
        end
        r0_last = 0;

        // r0 three-beat burst while r1 waits
        @(negedge clk); #3;
        chk("burst1_src", {127'd0, out_src}, 128'd0);
        chk("burst1_r1_ready", {127'd0, r1_ready}, 128'd0);
        chk("burst1_r0_ready", {127'd0, r0_ready}, 128'd1);
        @(negedge clk); #3;
        chk("burst2_src", {127'd0, out_src}, 128'd0);
        chk("burst2_r1_ready", {127'd0, r1_ready}, 128'd0);
        r0_last = 1;
        @(negedge clk); #3;
        chk("burst3_src", {127'd0, out_src}, 128'd0);
        r0_valid = 0;
        @(negedge clk); #3;
        chk("after_burst_src", {127'd0, out_src}, 128'd1);

        // back-pressure hold
        r1_valid = 0; r0_valid = 1; r0_last = 1; r0_data = {4{32'h1234_5678}}; r0_neg = 0;
        @(negedge clk); #3;
        out_ready = 0; r0_data = {4{32'h8765_4321}}; r0_neg = 1; r1_valid = 1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk); #3;
            chk("hold_data", out_data, {4{32'h1234_5678}});
            chk("hold_r0_ready", {127'd0, r0_ready}, 128'd0);
            chk("hold_r1_ready", {127'd0, r1_ready}, 128'd0);
            r0_abs = ~r0_abs;
        end
        out_ready = 1; r0_abs = 0;
        @(negedge clk); #3;
        chk("release_src", {127'd0, out_src}, 128'd1);
        chk("release_data", out_data, {4{32'hC000_0000}});

        // flush while locked on r0
        r1_valid = 0; r0_valid = 1; r0_last = 0;
        @(negedge clk); #3;
        chk("lock_src", {127'd0, out_src}, 128'd0);
        flush = 1;
        #1;
        chk("flush_r0_ready", {127'd0, r0_ready}, 128'd0);
        @(negedge clk); #3;
        chk("flush_valid", {127'd0, out_valid}, 128'd0);
        flush = 0; r1_valid = 1;
        #1;
        chk("post_flush_r1_ready", {127'd0, r1_ready}, 128'd1);
        chk("post_flush_r0_ready", {127'd0, r0_ready}, 128'd0);
        @(negedge clk);
        r1_valid = 0;
        @(negedge clk); #1;
        rst = 1;
        #1;
        chk("arst_valid", {127'd0, out_valid}, 128'd0);
        chk("arst_data", out_data, 128'd0);
        chk("arst_src", {127'd0, out_src}, 128'd0);
        chk("arst_r0_ready", {127'd0, r0_ready}, 128'd0);
        @(negedge clk);
        rst = 0; r0_valid = 0; r1_valid = 1;
        #1;
        chk("post_rst_r1_ready", {127'd0, r1_ready}, 128'd1);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            r0_valid = ($urandom_range(0, 9) < 6);
            r1_valid = ($urandom_range(0, 9) < 6);
            r0_last = ($urandom_range(0, 9) < 4);
            r1_last = ($urandom_range(0, 9) < 4);
            r0_neg = $urandom_range(0, 1); r0_abs = $urandom_range(0, 1);
            r1_neg = $urandom_range(0, 1); r1_abs = $urandom_range(0, 1);
            r0_tag = 4'($urandom); r1_tag = 4'($urandom);
            r0_data = {$urandom, $urandom, $urandom, $urandom};
            r1_data = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        rst = 0;
        idle_inputs();
        out_ready = 1;
        repeat (3) @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
